// File: rtl/vector_accumulator_if.sv
// Handshake bundle for vector_accumulator.
//   start/count        : job request (sampled in IDLE)
//   in_valid/in_ready  : product vector stream, product[LANES][DATA_WIDTH]
//   out_valid/out_ready: result handshake, acc_out[LANES][ACC_WIDTH], sat[LANES]
//   busy               : block is not IDLE
interface vector_accumulator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 16
);
  logic                                 start;
  logic [7:0]                           count;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0]     product;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [LANES-1:0][ACC_WIDTH-1:0]      acc_out;
  logic [LANES-1:0]                     sat;
  logic                                 busy;

  modport master (
    output start, count, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, sat, busy
  );

  modport slave (
    input  start, count, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, sat, busy
  );
endinterface

// File: rtl/vector_accumulator.sv
// Vector accumulator: sums a job of `count` product vectors lane by lane
// with per-lane saturation, then presents the result until taken.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : vector_accumulator_if.slave (job request, product stream, result)

// One lane: saturating accumulator with sticky saturation flag.
module vector_accumulator_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_xfer,
  input  logic [DATA_WIDTH-1:0] i_product,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_sat
);
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat;
  logic [ACC_WIDTH:0]   w_sum;

  // One extra bit catches the carry out that signals overflow.
  assign w_sum = {1'b0, r_acc} + {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, i_product};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_xfer) begin
      if (w_sum[ACC_WIDTH]) begin
        r_acc <= '1;
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign o_acc = r_acc;
  assign o_sat = r_sat;
endmodule

module vector_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 16
) (
  input logic                    clk,
  input logic                    rst,
  vector_accumulator_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [7:0]                      r_rem;
  logic                            w_clr;
  logic                            w_xfer;
  logic [LANES-1:0][ACC_WIDTH-1:0] w_acc;
  logic [LANES-1:0]                w_sat;

  // Start only counts in IDLE; this also drops a start that coincides
  // with the DONE handshake, since the FSM is still in DONE then.
  assign w_clr  = (r_state == S_IDLE) && bus.start;
  assign w_xfer = (r_state == S_ACCUM) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.count == 8'd0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_xfer && r_rem == 8'd1) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rem <= 8'd0;
    else if (w_clr)  r_rem <= bus.count;
    else if (w_xfer) r_rem <= r_rem - 8'd1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_accumulator_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_xfer   (w_xfer),
      .i_product(bus.product[g]),
      .o_acc    (w_acc[g]),
      .o_sat    (w_sat[g])
    );
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.acc_out   = w_acc;
  assign bus.sat       = w_sat;
endmodule

// File: tb/tb_vector_accumulator.sv
module tb_vector_accumulator;
  localparam int DW = 8;
  localparam int LN = 8;
  localparam int AW = 10;

  typedef logic [LN-1:0][AW-1:0] acc_t;
  typedef logic [LN-1:0][DW-1:0] prod_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  vector_accumulator_if #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW)) bus ();

  vector_accumulator #(.DATA_WIDTH(DW), .LANES(LN), .ACC_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t rep_acc(input int v);
    acc_t a;
    for (int i = 0; i < LN; i++) a[i] = AW'(v);
    return a;
  endfunction

  function automatic prod_t rep_prod(input int v);
    prod_t p;
    for (int i = 0; i < LN; i++) p[i] = DW'(v);
    return p;
  endfunction

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  acc_t  exp_a;
  prod_t p;

  initial begin
    bus.start = 0; bus.count = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.product = '0;
    #1;
    chk("rst_busy",      bus.busy, 0);
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc",       bus.acc_out, 0);
    chk("rst_sat",       bus.sat, 0);
    step(); step();
    rst = 0;
    step();
    chk("idle_busy", bus.busy, 0);

    // Basic job: 2+3+4 = 9
    bus.start = 1; bus.count = 3;
    step();
    bus.start = 0;
    chk("b_in_ready0", bus.in_ready, 1);
    chk("b_busy", bus.busy, 1);
    bus.in_valid = 1; bus.product = rep_prod(2);
    step();
    chk("b_in_ready1", bus.in_ready, 1);
    chk("b_acc1", bus.acc_out, rep_acc(2));
    bus.product = rep_prod(3);
    step();
    chk("b_in_ready2", bus.in_ready, 1);
    chk("b_acc2", bus.acc_out, rep_acc(5));
    bus.product = rep_prod(4);
    step();
    bus.in_valid = 0;
    chk("b_in_ready3", bus.in_ready, 0);
    chk("b_out_valid", bus.out_valid, 1);
    chk("b_acc", bus.acc_out, rep_acc(9));
    chk("b_sat", bus.sat, 0);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("b_hs_out_valid", bus.out_valid, 0);
    chk("b_hs_busy", bus.busy, 0);
    chk("b_hold_acc", bus.acc_out, rep_acc(9));

    // Zero count: straight to DONE, products ignored
    bus.start = 1; bus.count = 0; bus.in_valid = 1; bus.product = rep_prod(5);
    step();
    bus.start = 0;
    chk("z_out_valid", bus.out_valid, 1);
    chk("z_in_ready", bus.in_ready, 0);
    chk("z_acc", bus.acc_out, rep_acc(0));
    step();
    chk("z_acc_hold", bus.acc_out, rep_acc(0));
    bus.in_valid = 0; bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("z_idle", bus.busy, 0);

    // Saturation: lane0 255 x5 = 1275 -> clamp 1023; others 1 x5 = 5
    bus.start = 1; bus.count = 5;
    step();
    bus.start = 0;
    p = rep_prod(1); p[0] = 8'd255;
    bus.in_valid = 1; bus.product = p;
    step(); step(); step(); step();
    exp_a = rep_acc(4); exp_a[0] = 10'd1020;
    chk("s_acc4", bus.acc_out, exp_a);
    chk("s_sat4", bus.sat, 0);
    step();
    bus.in_valid = 0;
    exp_a = rep_acc(5); exp_a[0] = 10'd1023;
    chk("s_out_valid", bus.out_valid, 1);
    chk("s_acc", bus.acc_out, exp_a);
    chk("s_sat", bus.sat, 8'h01);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("s_sat_hold", bus.sat, 8'h01);

    // Backpressure + ignored start: beats 1,2,3,4 with gaps -> 10
    bus.start = 1; bus.count = 4;
    step();
    chk("p_sat_clr", bus.sat, 0);
    chk("p_acc_clr", bus.acc_out, rep_acc(0));
    for (int k = 1; k <= 4; k++) begin
      bus.in_valid = 1; bus.product = rep_prod(k);
      bus.start = (k == 2); bus.count = 1;
      step();
      if (k < 4) begin
        bus.in_valid = 0; bus.product = rep_prod(99); bus.start = 0;
        step();
        chk("p_gap_acc", bus.acc_out, rep_acc(k * (k + 1) / 2));
        chk("p_gap_ready", bus.in_ready, 1);
      end
    end
    bus.in_valid = 0; bus.start = 0;
    chk("p_out_valid", bus.out_valid, 1);
    chk("p_acc", bus.acc_out, rep_acc(10));
    bus.in_valid = 1; bus.product = rep_prod(50);
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2); bus.count = 7;
      step();
      chk("p_done_valid", bus.out_valid, 1);
      chk("p_done_acc", bus.acc_out, rep_acc(10));
    end
    bus.in_valid = 0;
    bus.start = 1; bus.count = 2; bus.out_ready = 1;
    step();
    bus.start = 0; bus.out_ready = 0;
    chk("p_hs_busy", bus.busy, 0);
    chk("p_hs_acc", bus.acc_out, rep_acc(10));
    step();
    chk("p_start_ignored", bus.busy, 0);

    // Reset mid-job
    bus.start = 1; bus.count = 4;
    step();
    bus.start = 0;
    bus.in_valid = 1; bus.product = rep_prod(6);
    step(); step();
    chk("r_acc_part", bus.acc_out, rep_acc(12));
    bus.in_valid = 0;
    #2 rst = 1;
    #1;
    chk("r_acc", bus.acc_out, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_in_ready", bus.in_ready, 0);
    chk("r_out_valid", bus.out_valid, 0);
    step();
    rst = 0;
    step();
    chk("r_no_partial", bus.out_valid, 0);
    bus.start = 1; bus.count = 1;
    step();
    bus.start = 0;
    bus.in_valid = 1; bus.product = rep_prod(7);
    step();
    bus.in_valid = 0;
    chk("r2_out_valid", bus.out_valid, 1);
    chk("r2_acc", bus.acc_out, rep_acc(7));
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("r2_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_accumulator.md
VECTOR_ACCUMULATOR -- requirements
Module: vector_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each incoming product lane.
REQ-002 The block SHALL have parameter LANES, default 8, giving the number of vector lanes.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 16, giving the width of each lane accumulator (ACC_WIDTH > DATA_WIDTH).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to begin an accumulation job; sampled only in IDLE.
REQ-007 count  input  8  number of product vectors in the job; sampled with start.
REQ-008 in_valid  input  1  product vector is present.
REQ-009 in_ready  output  1  block accepts a product vector this cycle.
REQ-010 product  input  [LANES-1:0][DATA_WIDTH-1:0]  unsigned per-lane products from the vector multiplier.
REQ-011 out_valid  output  1  the accumulated result is present.
REQ-012 out_ready  input  1  the consumer takes the result.
REQ-013 acc_out  output  [LANES-1:0][ACC_WIDTH-1:0]  per-lane accumulated sums.
REQ-014 sat  output  LANES  per-lane sticky saturation flags.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE with start=1 and count!=0, the block SHALL clear acc_out and sat, load the remaining-count register with count, and go to ACCUM on the next edge.
REQ-018 In IDLE with start=1 and count=0, the block SHALL clear acc_out and sat and go directly to DONE.
REQ-019 in_ready SHALL be 1 only in ACCUM, as a combinational decode of state.
REQ-020 A transfer SHALL occur on each edge where in_valid && in_ready.
REQ-021 On each transfer, each lane SHALL take acc_out[i] + zero-extended product[i]; if the result exceeds 2^ACC_WIDTH-1, the lane SHALL clamp to 2^ACC_WIDTH-1 and set sat[i].
REQ-022 sat[i] SHALL remain set until the next accepted start or reset.
REQ-023 On each transfer, the block SHALL decrement the remaining count; the transfer that brings it to 0 SHALL move the FSM to DONE on the same edge.
REQ-024 With no transfer in ACCUM, acc_out and the remaining count SHALL hold unchanged for any number of cycles.
REQ-025 out_valid SHALL be 1 only in DONE, so it is asserted in the cycle after the last transfer edge.
REQ-026 In DONE, acc_out and sat SHALL be stable, and the block SHALL remain in DONE until out_ready=1.
REQ-027 The edge with out_valid && out_ready SHALL return the FSM to IDLE; acc_out and sat SHALL hold their values until the next accepted start.
REQ-028 The block SHALL ignore start in ACCUM and DONE, with no effect on state, count or acc_out.
REQ-029 A start asserted in the same cycle as the DONE handshake SHALL be ignored; start becomes effective only from the following IDLE cycle.
REQ-030 Product data presented while in_ready=0 SHALL NOT affect any state.

Reset
REQ-031 While rst=1, the block SHALL immediately force state=IDLE, acc_out=0, sat=0 and remaining count=0, without waiting for a clock edge.
REQ-032 While rst=1, the outputs SHALL be in_ready=0, out_valid=0 and busy=0.
REQ-033 Reset asserted mid-job SHALL abandon the job; no partial result SHALL be presented afterwards.
REQ-034 After rst deasserts, the first edge SHALL behave as an IDLE edge.

Verification
REQ-035 Basic job: start with count=3, then products of 2, 3 and 4 on all lanes with in_valid held high -> in_ready high for 3 cycles, out_valid high in the following cycle, every acc_out lane=9, sat=0.
REQ-036 Zero count: start with count=0 -> out_valid=1 on the next cycle, all acc_out lanes=0, and no product accepted.
REQ-037 Saturation with ACC_WIDTH=10: count=5, lane0=255 and other lanes=1 every beat -> acc_out[0]=1023, sat[0]=1, other lanes=5 with sat=0.
REQ-038 Backpressure: in_valid toggled 1/0 during a count=4 job, then out_ready held 0 for 5 cycles in DONE -> acc_out equals the sum of exactly 4 beats, stays stable in DONE, and the FSM returns to IDLE one edge after out_ready=1.
REQ-039 Reset mid-operation: rst asserted after 2 of 4 beats -> outputs zero immediately; a following count=1 job with product=7 gives acc_out=7 on all lanes.
REQ-040 Ignored start: start pulsed during ACCUM and during DONE -> the job count is unchanged, and the result matches the original job.
